// File: rtl/reg_file.sv
// Register file: one write port, two registered read ports (1-cycle latency).
// Define REG_FILE_BYPASS_EN for write-first collisions; the default build is read-first.
module reg_file #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] wr_hit_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  function automatic logic is_zero_slot(input int idx);
    return (ZERO_REG != 32'sd0) && (idx == 32'sd0);
  endfunction

  // Out-of-range addresses match no slot, so they read 0 and never alias onto a real register.
  function automatic logic [WIDTH-1:0] read_mux(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      val = val | (mem_r[i] & {WIDTH{(addr == ADDR_W'(i)) && !is_zero_slot(i)}});
    end
`ifdef REG_FILE_BYPASS_EN
    if ((|wr_hit_s) && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = val;
    end
`endif
    return val;
  endfunction

  // Per-register write strobes; empty for dropped writes.
  always_comb begin
    wr_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit_s[i] = we && (waddr == ADDR_W'(i)) && !is_zero_slot(i);
    end
  end

  // Read data presented to the output registers.
  always_comb begin
    rd_a_s = read_mux(raddr_a);
    rd_b_s = read_mux(raddr_b);
  end

  // Storage and registered read ports; reset has priority over writes and reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit_s[i]) begin
          mem_r[i] <= wdata;
        end
      end
      if (re_a) begin
        rdata_a <= rd_a_s;
      end
      if (re_b) begin
        rdata_b <= rd_b_s;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed vector table plus randomized traffic against a behavioural model.
// Two instances share inputs: DEPTH=6/ZERO_REG=1 and DEPTH=8/ZERO_REG=0.
module tb_reg_file;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       re_a;
  logic [2:0] raddr_a;
  logic       re_b;
  logic [2:0] raddr_b;
  logic [7:0] rdata_a6, rdata_b6, rdata_a8, rdata_b8;

  int n_checks = 0;
  int n_errors = 0;

  reg_file #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a6),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b6)
  );

  reg_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a8),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [7:0] COLL = 8'h22;
  localparam bit BYP = 1'b1;
`else
  localparam logic [7:0] COLL = 8'h11;
  localparam bit BYP = 1'b0;
`endif

  // Behavioural model: index 0 is the DEPTH=6/ZERO_REG=1 instance, index 1 the DEPTH=8/ZERO_REG=0 one.
  int         dep [2] = '{6, 8};
  int         zr  [2] = '{1, 0};
  logic [7:0] mdl [2][8];
  logic [7:0] exp_a [2];
  logic [7:0] exp_b [2];

  typedef struct {
    logic       r;
    logic       w;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rea;
    logic [2:0] ra;
    logic       reb;
    logic [2:0] rb;
    logic [7:0] xa;
    logic [7:0] xb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic w, logic [2:0] wa, logic [7:0] wd,
                              logic rea, logic [2:0] ra, logic reb, logic [2:0] rb,
                              logic [7:0] xa, logic [7:0] xb);
    vec_t v;
    v.r = r; v.w = w; v.wa = wa; v.wd = wd; v.rea = rea; v.ra = ra;
    v.reb = reb; v.rb = rb; v.xa = xa; v.xb = xb;
    return v;
  endfunction

  function automatic logic [7:0] mread(int k, logic [2:0] a, logic wok, logic [2:0] wa, logic [7:0] wd);
    if (int'(a) >= dep[k]) return 8'h00;
    if (zr[k] != 0 && a == 3'd0) return 8'h00;
    if (BYP && wok && wa == a) return wd;
    return mdl[k][a];
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(logic r, logic w, logic [2:0] wa, logic [7:0] wd,
                      logic rea, logic [2:0] ra, logic reb, logic [2:0] rb,
                      bit use_tbl, logic [7:0] xa, logic [7:0] xb, int idx);
    logic wok;
    rst_n = r; we = w; waddr = wa; wdata = wd;
    re_a = rea; raddr_a = ra; re_b = reb; raddr_b = rb;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        for (int j = 0; j < 8; j++) mdl[k][j] = 8'h00;
        exp_a[k] = 8'h00;
        exp_b[k] = 8'h00;
      end else begin
        wok = w && (int'(wa) < dep[k]) && !(zr[k] != 0 && wa == 3'd0);
        if (rea) exp_a[k] = mread(k, ra, wok, wa, wd);
        if (reb) exp_b[k] = mread(k, rb, wok, wa, wd);
        if (wok) mdl[k][wa] = wd;
      end
    end
    #1;
    chk($sformatf("model_a6[%0d]", idx), rdata_a6, exp_a[0]);
    chk($sformatf("model_b6[%0d]", idx), rdata_b6, exp_b[0]);
    chk($sformatf("model_a8[%0d]", idx), rdata_a8, exp_a[1]);
    chk($sformatf("model_b8[%0d]", idx), rdata_b8, exp_b[1]);
    if (use_tbl) begin
      chk($sformatf("tbl_a[%0d]", idx), rdata_a6, xa);
      chk($sformatf("tbl_b[%0d]", idx), rdata_b6, xb);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
    re_a = 1'b0; raddr_a = 3'd0; re_b = 1'b0; raddr_b = 3'd0;
    for (int k = 0; k < 2; k++) begin
      exp_a[k] = 8'h00; exp_b[k] = 8'h00;
      for (int j = 0; j < 8; j++) mdl[k][j] = 8'h00;
    end

    // Expectations below are for the DEPTH=6, ZERO_REG=1 instance.
    //          r     w     wa    wd     rea   ra    reb   rb    xa     xb
    tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 1'b1, 3'd4, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd1, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd3, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd5, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd7, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd5, 8'hA5, 8'h3C));
    tbl.push_back(mk(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 8'h3C));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 3'd0, 8'hEE, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 1'b0, 3'd0, COLL,  8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2, 8'h22, 8'h22));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 8'h5A, 1'b0, 3'd1, 1'b0, 3'd0, 8'h22, 8'h22));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 1'b1, 3'd1, 8'h22, 8'h5A));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 1'b0, 3'd0, 8'h22, 8'h5A));
    tbl.push_back(mk(1'b1, 1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 1'b0, 3'd0, 8'h22, 8'h5A));
    tbl.push_back(mk(1'b1, 1'b1, 3'd7, 8'h77, 1'b1, 3'd7, 1'b1, 3'd6, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd3, 8'h5A, 8'hA5));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd2, 8'h3C, 8'h22));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd4, 8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 1'b1, 3'd3, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd3, 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd1, 8'h00, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].rea, tbl[i].ra,
           tbl[i].reb, tbl[i].rb, 1'b1, tbl[i].xa, tbl[i].xb, i);
    end

    // Randomized traffic, with occasional mid-run resets and frequent address collisions.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] wa_r;
      wa_r = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 31) != 0), 1'($urandom), wa_r, 8'($urandom),
           1'($urandom), ($urandom_range(0, 2) == 0) ? wa_r : 3'($urandom_range(0, 7)),
           1'($urandom), ($urandom_range(0, 2) == 0) ? wa_r : 3'($urandom_range(0, 7)),
           1'b0, 8'h00, 8'h00, 1000 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
